// File: rtl/mux_nto1_reg.sv
// Registered N:1 channel multiplexer. It has a manual select mode and a
// round-robin mode, and uses valid/ready handshakes on both the producer and consumer sides.
module mux_nto1_reg #(
  parameter int WIDTH = 16,
  parameter int N     = 16,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               res,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  cand;
  logic             cand_ok;
  logic             load_en;
  logic             grant;
  logic [SELW-1:0]  rr_next;
  logic [WIDTH-1:0] cand_data;

  // (base + off) mod N. The caller guarantees base < N and off < N.
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  assign load_en = !out_valid || out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    cand    = '0;
    cand_ok = 1'b0;
    if (mode == MODE_MANUAL) begin
      if (int'(sel) < N) begin
        if (in_valid[sel]) begin
          cand    = sel;
          cand_ok = 1'b1;
        end
      end
    end else begin
      // Walk from the farthest offset to the nearest one, so the nearest valid channel wins.
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[wrap_add(rr_ptr, i)]) begin
          cand    = wrap_add(rr_ptr, i);
          cand_ok = 1'b1;
        end
      end
    end
  end

  assign grant     = load_en && cand_ok && !res;
  assign in_ready  = grant ? (N'(1) << cand) : '0;
  assign cand_data = in_data[int'(cand) * WIDTH +: WIDTH];
  assign rr_next   = (int'(cand) == N - 1) ? '0 : cand + SELW'(1);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (res) begin
      // NOTE: the data register is reset as well, because its zero value is visible to the consumer.
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (grant) begin
      out_data  <= cand_data;
      out_chan  <= cand;
      out_valid <= 1'b1;
      if (mode == MODE_RR) rr_ptr <= rr_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg. A 16-channel instance covers the main behaviour,
// and a 5-channel instance covers non-power-of-two bounds and pointer wrap.
module tb_mux_nto1_reg;

  localparam int WA = 16, NA = 16, SA = 4;
  localparam int WB = 8,  NB = 5,  SB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic             res_a, mode_a, out_valid_a, out_ready_a;
  logic [NA*WA-1:0] in_data_a;
  logic [NA-1:0]    in_valid_a, in_ready_a;
  logic [SA-1:0]    sel_a, out_chan_a;
  logic [WA-1:0]    out_data_a;

  logic             res_b, mode_b, out_valid_b, out_ready_b;
  logic [NB*WB-1:0] in_data_b;
  logic [NB-1:0]    in_valid_b, in_ready_b;
  logic [SB-1:0]    sel_b, out_chan_b;
  logic [WB-1:0]    out_data_b;

  mux_nto1_reg #(.WIDTH(WA), .N(NA)) dut_a (
    .clk(clk), .res(res_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .sel(sel_a), .mode(mode_a), .out_data(out_data_a),
    .out_chan(out_chan_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  mux_nto1_reg #(.WIDTH(WB), .N(NB)) dut_b (
    .clk(clk), .res(res_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .sel(sel_b), .mode(mode_b), .out_data(out_data_b),
    .out_chan(out_chan_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  function automatic logic [WA-1:0] pat_a(input int k);
    return 16'hA000 + 16'(k);
  endfunction

  task automatic fill_a();
    for (int k = 0; k < NA; k++) in_data_a[k*WA +: WA] = pat_a(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_a = 1'b1; mode_a = 1'b1; sel_a = '0; out_ready_a = 1'b1; in_valid_a = '1;
    fill_a();
    tick();
    #1;
    checks++; if (in_ready_a !== 16'h0000) begin errors++; $display("FAIL reset_in_ready_hold: got %h expected 0000", in_ready_a); end
    tick();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_a); end
    checks++; if (out_data_a !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data_a); end
    checks++; if (out_chan_a !== 4'd0) begin errors++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan_a); end
    res_a = 1'b0;
    #1;
    checks++; if (in_ready_a !== 16'h0001) begin errors++; $display("FAIL reset_first_grant: got %h expected 0001", in_ready_a); end
    tick();
    checks++; if (out_valid_a !== 1'b1 || out_chan_a !== 4'd0 || out_data_a !== 16'hA000) begin errors++; $display("FAIL reset_first_word: got v=%0b c=%0d d=%h expected v=1 c=0 d=a000", out_valid_a, out_chan_a, out_data_a); end
    in_valid_a = '0;
    #1;
    checks++; if (in_ready_a !== 16'h0000) begin errors++; $display("FAIL reset_idle_ready: got %h expected 0000", in_ready_a); end
    tick();
    checks++; if (out_valid_a !== 1'b0 || out_data_a !== 16'hA000) begin errors++; $display("FAIL reset_drain: got v=%0b d=%h expected v=0 d=a000", out_valid_a, out_data_a); end
  endtask

  task automatic test_manual();
    mode_a = 1'b0; sel_a = 4'd5; in_valid_a = 16'h0020; out_ready_a = 1'b1;
    in_data_a[5*WA +: WA] = 16'hBEEF;
    #1;
    checks++; if (in_ready_a !== 16'h0020) begin errors++; $display("FAIL manual_in_ready: got %h expected 0020", in_ready_a); end
    tick();
    checks++; if (out_data_a !== 16'hBEEF || out_chan_a !== 4'd5 || out_valid_a !== 1'b1) begin errors++; $display("FAIL manual_word: got d=%h c=%0d v=%0b expected d=beef c=5 v=1", out_data_a, out_chan_a, out_valid_a); end
    in_valid_a = 16'h0040;
    #1;
    checks++; if (in_ready_a !== 16'h0000) begin errors++; $display("FAIL manual_unselected: got %h expected 0000", in_ready_a); end
    tick();
    checks++; if (out_valid_a !== 1'b0 || out_data_a !== 16'hBEEF || out_chan_a !== 4'd5) begin errors++; $display("FAIL manual_drain: got v=%0b d=%h c=%0d expected v=0 d=beef c=5", out_valid_a, out_data_a, out_chan_a); end
  endtask

  task automatic test_round_robin();
    int exp_chan[5] = '{0, 5, 10, 15, 0};
    logic [NA-1:0] one;
    one = 16'h0001;
    res_a = 1'b1;
    tick();
    res_a = 1'b0; mode_a = 1'b1; in_valid_a = 16'h8421; out_ready_a = 1'b1;
    fill_a();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready_a !== (one << exp_chan[i])) begin errors++; $display("FAIL rr_in_ready[%0d]: got %h expected %h", i, in_ready_a, one << exp_chan[i]); end
      tick();
      checks++; if (out_chan_a !== 4'(exp_chan[i]) || out_data_a !== pat_a(exp_chan[i]) || out_valid_a !== 1'b1) begin errors++; $display("FAIL rr_word[%0d]: got c=%0d d=%h v=%0b expected c=%0d d=%h v=1", i, out_chan_a, out_data_a, out_valid_a, exp_chan[i], pat_a(exp_chan[i])); end
    end
  endtask

  task automatic test_back_pressure();
    out_ready_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid_a = 16'h0F0F ^ 16'(c);
      mode_a = c[0];
      sel_a = 4'(c);
      for (int k = 0; k < NA; k++) in_data_a[k*WA +: WA] = 16'h1234 + 16'(c);
      #1;
      checks++; if (in_ready_a !== 16'h0000) begin errors++; $display("FAIL stall_in_ready[%0d]: got %h expected 0000", c, in_ready_a); end
      tick();
      checks++; if (out_data_a !== 16'hA000 || out_chan_a !== 4'd0 || out_valid_a !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got d=%h c=%0d v=%0b expected d=a000 c=0 v=1", c, out_data_a, out_chan_a, out_valid_a); end
    end
    out_ready_a = 1'b1; mode_a = 1'b1; in_valid_a = 16'h0100;
    in_data_a[8*WA +: WA] = 16'hC0DE;
    #1;
    checks++; if (in_ready_a !== 16'h0100) begin errors++; $display("FAIL stall_release_ready: got %h expected 0100", in_ready_a); end
    tick();
    checks++; if (out_data_a !== 16'hC0DE || out_chan_a !== 4'd8 || out_valid_a !== 1'b1) begin errors++; $display("FAIL stall_reload: got d=%h c=%0d v=%0b expected d=c0de c=8 v=1", out_data_a, out_chan_a, out_valid_a); end
    in_valid_a = '0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    mode_a = 1'b1; in_valid_a = 16'h0008; out_ready_a = 1'b1;
    in_data_a[3*WA +: WA] = 16'h3333;
    #1;
    checks++; if (in_ready_a !== 16'h0008) begin errors++; $display("FAIL mid_grant_ready: got %h expected 0008", in_ready_a); end
    tick();
    out_ready_a = 1'b0; in_valid_a = '1;
    tick();
    checks++; if (out_valid_a !== 1'b1 || out_data_a !== 16'h3333 || out_chan_a !== 4'd3) begin errors++; $display("FAIL mid_stall_word: got v=%0b d=%h c=%0d expected v=1 d=3333 c=3", out_valid_a, out_data_a, out_chan_a); end
    res_a = 1'b1;
    #1;
    checks++; if (in_ready_a !== 16'h0000) begin errors++; $display("FAIL mid_reset_ready: got %h expected 0000", in_ready_a); end
    tick();
    checks++; if (out_valid_a !== 1'b0 || out_data_a !== 16'h0000 || out_chan_a !== 4'd0) begin errors++; $display("FAIL mid_reset_clear: got v=%0b d=%h c=%0d expected v=0 d=0000 c=0", out_valid_a, out_data_a, out_chan_a); end
    res_a = 1'b0; out_ready_a = 1'b1;
    fill_a();
    #1;
    checks++; if (in_ready_a !== 16'h0001) begin errors++; $display("FAIL mid_restart_ready: got %h expected 0001", in_ready_a); end
    tick();
    checks++; if (out_chan_a !== 4'd0 || out_data_a !== 16'hA000) begin errors++; $display("FAIL mid_restart_word: got c=%0d d=%h expected c=0 d=a000", out_chan_a, out_data_a); end
    checks++; if (in_ready_a !== 16'h0002) begin errors++; $display("FAIL mid_next_ready: got %h expected 0002", in_ready_a); end
    tick();
    checks++; if (out_chan_a !== 4'd1 || out_data_a !== 16'hA001 || out_valid_a !== 1'b1) begin errors++; $display("FAIL mid_next_word: got c=%0d d=%h v=%0b expected c=1 d=a001 v=1", out_chan_a, out_data_a, out_valid_a); end
  endtask

  task automatic test_boundary();
    res_b = 1'b1; mode_b = 1'b0; sel_b = '0; in_valid_b = '0; out_ready_b = 1'b1;
    for (int k = 0; k < NB; k++) in_data_b[k*WB +: WB] = 8'h10 + 8'(k);
    tick();
    res_b = 1'b0; sel_b = 3'd2; in_valid_b = 5'b00100;
    #1;
    checks++; if (in_ready_b !== 5'b00100) begin errors++; $display("FAIL bnd_manual_ready: got %b expected 00100", in_ready_b); end
    tick();
    checks++; if (out_data_b !== 8'h12 || out_chan_b !== 3'd2 || out_valid_b !== 1'b1) begin errors++; $display("FAIL bnd_manual_word: got d=%h c=%0d v=%0b expected d=12 c=2 v=1", out_data_b, out_chan_b, out_valid_b); end
    sel_b = 3'd7; in_valid_b = 5'b11111;
    #1;
    checks++; if (in_ready_b !== 5'b00000) begin errors++; $display("FAIL bnd_sel_oor_ready: got %b expected 00000", in_ready_b); end
    tick();
    checks++; if (out_valid_b !== 1'b0 || out_data_b !== 8'h12 || out_chan_b !== 3'd2) begin errors++; $display("FAIL bnd_sel_oor_drain: got v=%0b d=%h c=%0d expected v=0 d=12 c=2", out_valid_b, out_data_b, out_chan_b); end
    mode_b = 1'b1; in_valid_b = 5'b01000;
    #1;
    checks++; if (in_ready_b !== 5'b01000) begin errors++; $display("FAIL bnd_rr_c3_ready: got %b expected 01000", in_ready_b); end
    tick();
    in_valid_b = 5'b10001;
    #1;
    checks++; if (in_ready_b !== 5'b10000) begin errors++; $display("FAIL bnd_rr_ptr4_ready: got %b expected 10000", in_ready_b); end
    tick();
    checks++; if (out_chan_b !== 3'd4 || out_data_b !== 8'h14) begin errors++; $display("FAIL bnd_rr_c4_word: got c=%0d d=%h expected c=4 d=14", out_chan_b, out_data_b); end
    checks++; if (in_ready_b !== 5'b00001) begin errors++; $display("FAIL bnd_rr_wrap_ready: got %b expected 00001", in_ready_b); end
    tick();
    checks++; if (out_chan_b !== 3'd0 || out_data_b !== 8'h10 || out_valid_b !== 1'b1) begin errors++; $display("FAIL bnd_rr_c0_word: got c=%0d d=%h v=%0b expected c=0 d=10 v=1", out_chan_b, out_data_b, out_valid_b); end
    checks++; if (in_ready_b !== 5'b10000) begin errors++; $display("FAIL bnd_rr_ptr1_ready: got %b expected 10000", in_ready_b); end
    tick();
  endtask

  initial begin
    res_b = 1'b1; mode_b = 1'b0; sel_b = '0; in_valid_b = '0; out_ready_b = 1'b1; in_data_b = '0;
    test_reset();
    test_manual();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_stall();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
